// File: rtl/xor_gate_bus_pipelined.sv
// xor_gate_bus_pipelined: N-input bus XOR/one-hot reduction, 2-stage valid/ready pipe, XOR chain accumulator; XOR_BUS_PARITY_OUT_EN adds Parity
module xor_gate_bus_pipelined #(
  parameter int NrOfBits = 8,
  parameter int NrOfInputs = 4,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0,
  parameter bit OneHot = 1'b1
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Tick,
  input  logic [NrOfInputs*NrOfBits-1:0] Inputs,
  input  logic                           In_Valid,
  output logic                           In_Ready,
  input  logic                           Chain,
  output logic [NrOfBits-1:0]            Result,
  output logic                           Out_Valid,
  input  logic                           Out_Ready,
  output logic [7:0]                     Count
`ifdef XOR_BUS_PARITY_OUT_EN
  ,
  output logic                           Parity
`endif
);
  logic                advance, s1_valid, s1_chain;
  logic [NrOfBits-1:0] bits, seen, many, odd, one, s1_odd, s1_one, w, next_result;
  assign advance = Tick & (~Out_Valid | Out_Ready);
  assign In_Ready = advance & ~Reset;
  always_comb begin
    bits = '0;
    seen = '0;
    many = '0;
    odd = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      bits = Inputs[i*NrOfBits +: NrOfBits] ^ {NrOfBits{BubblesMask[i]}};
      many = many | (seen & bits);
      seen = seen | bits;
      odd = odd ^ bits;
    end
    one = seen & ~many;
  end
  assign w = OneHot ? s1_one : s1_odd;
  assign next_result = s1_chain ? Result ^ w : w;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_chain <= 1'b0;
      s1_odd <= '0;
      s1_one <= '0;
    end else if (advance) begin
      s1_valid <= In_Valid & In_Ready;
      s1_chain <= Chain;
      s1_odd <= odd;
      s1_one <= one;
    end
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Out_Valid <= 1'b0;
      Result <= '0;
      Count <= '0;
    end else if (advance) begin
      Out_Valid <= s1_valid;
      if (s1_valid) begin
        Result <= next_result;
        Count <= !s1_chain ? 8'd1 : (&Count ? Count : Count + 8'd1);
      end
    end
  end
`ifdef XOR_BUS_PARITY_OUT_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Parity <= 1'b0;
    else if (advance && s1_valid) Parity <= ^next_result;
  end
`endif
endmodule
